// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler for the shared SDRAM frame buffer: camera writes vs VGA reads.
// Optional write-starvation guard enabled by defining SDRAM_ARB_STARVE_GUARD_EN.
module sdram_burst_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int WR_BASE      = 0,
  parameter int RD_BASE      = 0,
  parameter int FRAME_WORDS  = 307200,
  parameter int BURST_LEN    = 256,
  parameter int FIFO_AW      = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_LOAD,
  input  logic              iRD_LOAD,
  input  logic [FIFO_AW:0]  iWR_FIFO_USED,
  input  logic [FIFO_AW:0]  iRD_FIFO_USED,
  output logic              oCMD_VALID,
  output logic              oCMD_WRITE,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  output logic [8:0]        oCMD_LEN,
  input  logic              iCMD_ACK,
  input  logic              iCMD_DONE,
  output logic              oWR_FRAME_DONE,
  output logic              oRD_FRAME_DONE,
  output logic              oBUSY
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] WR_END = PW'(WR_BASE) + PW'(FRAME_WORDS);
  localparam logic [PW-1:0] RD_END = PW'(RD_BASE) + PW'(FRAME_WORDS);
  localparam logic [PW-1:0] BL_P = PW'(BURST_LEN);
  localparam logic [FIFO_AW:0] BL_F = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0] WR_B = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] RD_B = ADDR_W'(RD_BASE);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] sel_ptr, cur_ptr;
  logic [PW-1:0] sel_end, cur_end, remain, adv;
  logic [8:0] len_n;
  logic wr_req, rd_req, any_req;
  logic grant_wr, ack_fire, wrap;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
`endif

  always_comb begin
    wr_req  = iWR_FIFO_USED >= BL_F;
    rd_req  = iRD_FIFO_USED < BL_F;
    any_req = wr_req || rd_req;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    grant_wr = wr_req &&
      (!rd_req || starve_cnt == SW'(STARVE_LIMIT));
`else
    grant_wr = wr_req && !rd_req;
`endif
    sel_ptr = grant_wr ? wr_ptr : rd_ptr;
    sel_end = grant_wr ? WR_END : RD_END;
    remain  = sel_end - {1'b0, sel_ptr};
    len_n   = (remain < BL_P) ? remain[8:0] : BL_P[8:0];
    // advance from the live pointer so an earlier reload is honoured
    cur_ptr  = oCMD_WRITE ? wr_ptr : rd_ptr;
    cur_end  = oCMD_WRITE ? WR_END : RD_END;
    adv      = {1'b0, cur_ptr} + PW'(oCMD_LEN);
    wrap     = adv == cur_end;
    ack_fire = (state == REQ) && iCMD_ACK;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (any_req) state_n = REQ;
      REQ: if (iCMD_ACK) state_n = iCMD_DONE ? IDLE : BUSY;
      BUSY: if (iCMD_DONE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign oBUSY = state != IDLE;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oCMD_VALID     <= 1'b0;
      oCMD_WRITE     <= 1'b0;
      oCMD_ADDR      <= '0;
      oCMD_LEN       <= '0;
      oWR_FRAME_DONE <= 1'b0;
      oRD_FRAME_DONE <= 1'b0;
      wr_ptr         <= WR_B;
      rd_ptr         <= RD_B;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      starve_cnt     <= '0;
`endif
    end else begin
      oWR_FRAME_DONE <= 1'b0;
      oRD_FRAME_DONE <= 1'b0;
      if (state == IDLE && any_req) begin
        oCMD_VALID <= 1'b1;
        oCMD_WRITE <= grant_wr;
        oCMD_ADDR  <= sel_ptr;
        oCMD_LEN   <= len_n;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        if (grant_wr)
          starve_cnt <= '0;
        else if (wr_req && starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 1'b1;
`endif
      end
      if (ack_fire) begin
        oCMD_VALID <= 1'b0;
        if (oCMD_WRITE) begin
          wr_ptr         <= wrap ? WR_B : adv[ADDR_W-1:0];
          oWR_FRAME_DONE <= wrap && !iWR_LOAD;
        end else begin
          rd_ptr         <= wrap ? RD_B : adv[ADDR_W-1:0];
          oRD_FRAME_DONE <= wrap && !iRD_LOAD;
        end
      end
      // reload wins over a same-cycle advance
      if (iWR_LOAD) wr_ptr <= WR_B;
      if (iRD_LOAD) rd_ptr <= RD_B;
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_sdram_burst_arbiter;

  localparam int ADDR_W       = 23;
  localparam int WR_BASE      = 0;
  localparam int RD_BASE      = 4096;
  localparam int FRAME_WORDS  = 1000;
  localparam int BURST_LEN    = 256;
  localparam int FIFO_AW      = 9;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_load = 1'b0, rd_load = 1'b0;
  logic [FIFO_AW:0] wr_used = '0, rd_used = '0;
  logic cmd_ack = 1'b0, cmd_done = 1'b0;
  logic cmd_valid, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0] cmd_len;
  logic wr_frame_done, rd_frame_done, busy;

  always #5 clk = ~clk;

  sdram_burst_arbiter #(
    .ADDR_W(ADDR_W), .WR_BASE(WR_BASE), .RD_BASE(RD_BASE),
    .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN),
    .FIFO_AW(FIFO_AW), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .iCLK(clk), .iRST(rst),
    .iWR_LOAD(wr_load), .iRD_LOAD(rd_load),
    .iWR_FIFO_USED(wr_used), .iRD_FIFO_USED(rd_used),
    .oCMD_VALID(cmd_valid), .oCMD_WRITE(cmd_write),
    .oCMD_ADDR(cmd_addr), .oCMD_LEN(cmd_len),
    .iCMD_ACK(cmd_ack), .iCMD_DONE(cmd_done),
    .oWR_FRAME_DONE(wr_frame_done),
    .oRD_FRAME_DONE(rd_frame_done),
    .oBUSY(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_wfd = 0;
  int n_rfd = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: phase 0 = nothing outstanding,
  // 1 = command offered, 2 = accepted and running
  int m_phase, m_wr_ptr, m_rd_ptr, m_starve;
  int m_addr, m_len;
  bit m_valid, m_write, m_wfd, m_rfd;

  task automatic model_reset();
    m_phase = 0; m_wr_ptr = WR_BASE; m_rd_ptr = RD_BASE;
    m_starve = 0; m_addr = 0; m_len = 0;
    m_valid = 0; m_write = 0; m_wfd = 0; m_rfd = 0;
  endtask

  task automatic model_step();
    bit wreq, rreq, gw;
    int left, nxt;
    wreq = int'(wr_used) >= BURST_LEN;
    rreq = int'(rd_used) < BURST_LEN;
    m_wfd = 0;
    m_rfd = 0;
    if (m_phase == 0 && (wreq || rreq)) begin
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      gw = wreq && (!rreq || m_starve == STARVE_LIMIT);
      if (gw) m_starve = 0;
      else if (wreq && m_starve < STARVE_LIMIT) m_starve++;
`else
      gw = wreq && !rreq;
`endif
      m_write = gw;
      m_addr  = gw ? m_wr_ptr : m_rd_ptr;
      left    = (gw ? WR_BASE : RD_BASE) + FRAME_WORDS - m_addr;
      m_len   = left < BURST_LEN ? left : BURST_LEN;
      m_valid = 1;
      m_phase = 1;
    end else if (m_phase == 1 && cmd_ack) begin
      m_valid = 0;
      m_phase = cmd_done ? 0 : 2;
      if (m_write) begin
        nxt = m_wr_ptr + m_len;
        if (nxt == WR_BASE + FRAME_WORDS) begin
          m_wr_ptr = WR_BASE; m_wfd = !wr_load;
        end else m_wr_ptr = nxt;
      end else begin
        nxt = m_rd_ptr + m_len;
        if (nxt == RD_BASE + FRAME_WORDS) begin
          m_rd_ptr = RD_BASE; m_rfd = !rd_load;
        end else m_rd_ptr = nxt;
      end
    end else if (m_phase == 2 && cmd_done) begin
      m_phase = 0;
    end
    if (wr_load) m_wr_ptr = WR_BASE;
    if (rd_load) m_rd_ptr = RD_BASE;
  endtask

  task automatic compare_all();
    check("valid", 32'(cmd_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("wr_frame_done", 32'(wr_frame_done), 32'(m_wfd));
    check("rd_frame_done", 32'(rd_frame_done), 32'(m_rfd));
    if (m_valid) begin
      check("write", 32'(cmd_write), 32'(m_write));
      check("addr", 32'(cmd_addr), m_addr);
      check("len", 32'(cmd_len), m_len);
    end
  endtask

  // starts and ends on a falling edge
  task automatic cycle(input int wu, input int ru,
                       input bit ack, input bit done,
                       input bit wl, input bit rl);
    wr_used = (FIFO_AW+1)'(wu);
    rd_used = (FIFO_AW+1)'(ru);
    cmd_ack = ack; cmd_done = done;
    wr_load = wl; rd_load = rl;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (wr_frame_done === 1'b1) n_wfd++;
    if (rd_frame_done === 1'b1) n_rfd++;
    @(negedge clk);
  endtask

  task automatic serve(input int wu, input int ru, input bit rl_ack,
                       output bit w, output int a, output int l);
    int k = 0;
    cycle(wu, ru, 0, 0, 0, 0);
    while (cmd_valid !== 1'b1 && k < 4) begin
      cycle(wu, ru, 0, 0, 0, 0);
      k++;
    end
    check("serve_offer", 32'(cmd_valid), 1);
    w = cmd_write;
    a = int'(cmd_addr);
    l = int'(cmd_len);
    if (rl_ack) begin
      cycle(wu, ru, 1, 0, 0, 1);
      cycle(wu, ru, 0, 1, 0, 0);
    end else begin
      cycle(wu, ru, 1, 1, 0, 0);
    end
  endtask

  initial begin
    bit w;
    int a, l, nw, rf0;
    model_reset();
    @(negedge clk);
    #1;
    compare_all();
    check("rst_len", 32'(cmd_len), 0);
    check("rst_addr", 32'(cmd_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // read request offered one cycle after reset release
    cycle(0, 0, 0, 0, 0, 0);
    check("t1_valid", 32'(cmd_valid), 1);
    check("t1_write", 32'(cmd_write), 0);
    check("t1_addr", 32'(cmd_addr), RD_BASE);
    check("t1_len", 32'(cmd_len), 256);
    cycle(0, 0, 1, 1, 0, 0);
    serve(0, 0, 0, w, a, l);
    check("t1_adv", a, RD_BASE + 256);

    // write-only request, ACK and DONE together
    serve(300, 500, 0, w, a, l);
    check("t2_write", 32'(w), 1);
    check("t2_addr", a, WR_BASE);
    check("t2_idle", 32'(busy), 0);
    serve(300, 500, 0, w, a, l);
    check("t2_adv", a, WR_BASE + 256);

    // full write frame: 256,256,256,232 then wrap
    cycle(0, 500, 0, 0, 1, 1);
    n_wfd = 0;
    for (int i = 0; i < 4; i++) serve(300, 500, 0, w, a, l);
    check("t3_last_len", l, FRAME_WORDS - 3 * BURST_LEN);
    check("t3_pulses", n_wfd, 1);
    serve(300, 500, 0, w, a, l);
    check("t3_wrap_addr", a, WR_BASE);

    // both sides requesting
    cycle(0, 500, 0, 0, 1, 1);
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      serve(300, 0, 0, w, a, l);
      nw += int'(w);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      if (i == 4) check("t4_fifth_is_write", 32'(w), 1);
`endif
    end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    check("t4_writes", nw, 2);
`else
    check("t4_writes", nw, 0);
`endif

    // read reload on the ACK cycle
    cycle(0, 500, 0, 0, 1, 1);
    serve(0, 0, 0, w, a, l);
    serve(0, 0, 0, w, a, l);
    rf0 = n_rfd;
    serve(0, 0, 1, w, a, l);
    check("t5_addr", a, RD_BASE + 512);
    check("t5_no_pulse", n_rfd - rf0, 0);
    serve(0, 0, 0, w, a, l);
    check("t5_reload", a, RD_BASE);

    // reset while a burst is running
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("t6_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("t6_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    serve(300, 500, 0, w, a, l);
    check("t6_wr_base", a, WR_BASE);
    serve(0, 0, 0, w, a, l);
    check("t6_rd_base", a, RD_BASE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 511), $urandom_range(0, 511),
            ($urandom % 2) == 0, ($urandom % 3) == 0,
            ($urandom % 40) == 0, ($urandom % 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
